// File: rtl/led_sequencer.sv
// led_sequencer: debounces a step button and a mode button, and sequences a
// 2-bit colour code either by hand (one advance per step press) or
// automatically (one advance every STEP_CYCLES clocks while in AUTO).
//
// Mode FSM states:
//   state  | meaning
//   -------+---------------------------------------------------------------
//   MANUAL | code advances only on step presses; prescaler held at 0
//   AUTO   | code also advances on each prescaler tick; auto_mode high
module led_sequencer #(
    parameter int DEB_CYCLES  = 240000,
    parameter int STEP_CYCLES = 12000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_step_n,
    input  logic       btn_mode_n,
    output logic [1:0] code,
    output logic       auto_mode,
    output logic       step_pulse
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(STEP_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYCLES - 1);

    // Button lanes: bit 0 is the step button, bit 1 is the mode button.
    localparam int BTN_STEP = 0;
    localparam int BTN_MODE = 1;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_t;

    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    press_q, press_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];

    mode_t         mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    code_q, code_d;
    logic          auto_mode_q, auto_mode_d;
    logic          step_pulse_q, step_pulse_d;

    logic          step_ev;
    logic          mode_ev;
    logic          tick;
    logic          leaving_auto;
    logic          advance;

    assign btn_raw = {btn_mode_n, btn_step_n};

    // Synchronize, debounce and falling-edge detect both buttons.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        press_d = 2'b00;
        for (int i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            // The counter only survives while the synchronized level keeps
            // disagreeing with the debounced level; any agreement clears it.
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
            // Press is registered so it is high in the first cycle the
            // debounced level reads 0; releases produce nothing.
            press_d[i] = deb_q[i] & ~deb_d[i];
        end
    end

    // Mode FSM, prescaler and code sequencing.
    always_comb begin
        step_ev      = press_q[BTN_STEP];
        mode_ev      = press_q[BTN_MODE];
        tick         = (mode_q == AUTO) && (presc_q == PRE_LAST);
        leaving_auto = mode_ev && (mode_q == AUTO);

        mode_d = mode_q;
        if (mode_ev) begin
            mode_d = (mode_q == AUTO) ? MANUAL : AUTO;
        end

        // A tick in the cycle we drop back to MANUAL is thrown away; a step
        // press coinciding with a tick still only advances once.
        advance = step_ev | (tick & ~leaving_auto);

        // Prescaler runs only while staying in AUTO; entering AUTO, a step
        // press, a tick or leaving AUTO all return it to 0.
        presc_d = '0;
        if ((mode_q == AUTO) && (mode_d == AUTO) && !step_ev && !tick) begin
            presc_d = presc_q + PW'(1);
        end

        code_d       = advance ? (code_q + 2'd1) : code_q;
        step_pulse_d = advance;
        auto_mode_d  = (mode_d == AUTO);
    end

    // All state, cleared asynchronously to the released/idle condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            deb_q        <= 2'b11;
            press_q      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
            mode_q       <= MANUAL;
            presc_q      <= '0;
            code_q       <= 2'b00;
            auto_mode_q  <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            press_q      <= press_d;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            mode_q       <= mode_d;
            presc_q      <= presc_d;
            code_q       <= code_d;
            auto_mode_q  <= auto_mode_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign code       = code_q;
    assign auto_mode  = auto_mode_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer with DEB_CYCLES=4, STEP_CYCLES=8. Stimulus pushes
// expected advances (code value plus allowed cycle window) into a queue; a
// negedge monitor pops one entry per step_pulse and compares.
module tb_led_sequencer;

    localparam int DEB  = 4;
    localparam int STEP = 8;
    // Button-low to code-change latency: 2 sync + debounce + edge + register.
    localparam int LAT  = 2 + DEB + 1 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_step_n = 1'b1;
    logic       btn_mode_n = 1'b1;
    logic [1:0] code;
    logic       auto_mode;
    logic       step_pulse;

    led_sequencer #(.DEB_CYCLES(DEB), .STEP_CYCLES(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_step_n (btn_step_n),
        .btn_mode_n (btn_mode_n),
        .code       (code),
        .auto_mode  (auto_mode),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    code;
        int    lo;
        int    hi;
        bit    rel;   // window measured from the previous advance
        string name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    int   last_adv = 0;
    int   model_code = 0;
    logic [1:0] prev_code = 2'b00;
    exp_t mon_e;
    int   mon_lo, mon_hi;

    function automatic void check(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void push(int c, int lo, int hi, bit rel, string nm);
        exp_t x;
        x.code = c; x.lo = lo; x.hi = hi; x.rel = rel; x.name = nm;
        sbq.push_back(x);
    endfunction

    // Monitor: every step_pulse must match the next expected advance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_code = code;
        end else begin
            if (step_pulse) begin
                pulses++;
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pulse: step_pulse at cycle %0d with code=%0d, none expected", cyc, code);
                end else begin
                    mon_e  = sbq.pop_front();
                    mon_lo = mon_e.rel ? last_adv + mon_e.lo : mon_e.lo;
                    mon_hi = mon_e.rel ? last_adv + mon_e.hi : mon_e.hi;
                    check({mon_e.name, "_code"}, int'(code), mon_e.code);
                    total++;
                    if (cyc < mon_lo || cyc > mon_hi) begin
                        bad++;
                        $display("FAIL %s_timing: advance at cycle %0d, required %0d..%0d", mon_e.name, cyc, mon_lo, mon_hi);
                    end
                end
                last_adv = cyc;
            end
            if (step_pulse || code != prev_code) begin
                total++;
                if ((code != prev_code) != step_pulse) begin
                    bad++;
                    $display("FAIL pulse_vs_code: step_pulse=%0d code %0d->%0d at cycle %0d", step_pulse, prev_code, code, cyc);
                end
            end
            prev_code = code;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit which, input int c0, input int hold);
        wait_cyc(c0);
        if (which) btn_mode_n = 1'b0; else btn_step_n = 1'b0;
        idle(hold);
        btn_mode_n = 1'b1;
        btn_step_n = 1'b1;
    endtask

    task automatic drain(input int budget, input string nm);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d expected advances still pending after %0d cycles", nm, sbq.size(), budget);
            sbq.delete();
        end
    endtask

    task automatic manual_step(input int hold, input int gap);
        int c0;
        c0 = cyc + 1;
        model_code = (model_code + 1) % 4;
        push(model_code, c0 + LAT - 1, c0 + LAT + 1, 1'b0, "manual_step");
        press(1'b0, c0, hold);
        idle(gap);
    endtask

    // Press mode (optionally with step) at c0 and wait for auto_mode to flip.
    task automatic mode_press(input bit with_step, input bit want, input int c0, output int r);
        int k;
        wait_cyc(c0);
        btn_mode_n = 1'b0;
        if (with_step) btn_step_n = 1'b0;
        r = -1;
        k = 0;
        while (k < 20 && (r < 0 || k < 10)) begin
            @(negedge clk);
            k++;
            if (k == 10) begin
                btn_mode_n = 1'b1;
                btn_step_n = 1'b1;
            end
            if (r < 0 && auto_mode == want) r = cyc;
        end
        btn_mode_n = 1'b1;
        btn_step_n = 1'b1;
        total++;
        if (r < c0 + LAT - 1 || r > c0 + LAT + 1) begin
            bad++;
            $display("FAIL mode_change: auto_mode=%0d seen at cycle %0d, required %0d..%0d", want, r, c0 + LAT - 1, c0 + LAT + 1);
        end
    endtask

    initial begin
        int r, L, c0, n, off, p0, k;

        // Reset state, before any clock edge.
        #3;
        check("reset_code", int'(code), 0);
        check("reset_auto", int'(auto_mode), 0);
        check("reset_pulse", int'(step_pulse), 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        check("post_reset_code", int'(code), 0);
        check("post_reset_auto", int'(auto_mode), 0);

        // Glitches shorter than the debounce window are discarded.
        press(1'b0, cyc + 1, 3);
        idle(12);
        for (int i = 0; i < 4; i++) begin
            press(1'b0, cyc + 1, $urandom_range(1, 3));
            idle($urandom_range(8, 15));
        end
        press(1'b1, cyc + 1, $urandom_range(1, 3));
        idle(12);
        check("glitch_code", int'(code), 0);
        check("glitch_auto", int'(auto_mode), 0);

        // Four clean presses, then one long hold.
        p0 = pulses;
        for (int i = 0; i < 4; i++) manual_step(20, 15);
        drain(40, "four_presses");
        check("four_presses_count", pulses - p0, 4);
        check("four_presses_code", int'(code), model_code);
        p0 = pulses;
        manual_step(100, 20);
        drain(40, "long_hold");
        check("long_hold_count", pulses - p0, 1);

        // Random manual presses.
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) manual_step($urandom_range(6, 30), $urandom_range(10, 25));
        drain(40, "random_manual");
        check("random_manual_code", int'(code), model_code);

        // Enter AUTO: first tick STEP cycles after auto_mode rises.
        mode_press(1'b0, 1'b1, cyc + 1, r);
        n = $urandom_range(3, 6);
        model_code = (model_code + 1) % 4;
        push(model_code, r + STEP, r + STEP, 1'b0, "first_tick");
        for (int i = 1; i < n; i++) begin
            model_code = (model_code + 1) % 4;
            push(model_code, STEP, STEP, 1'b1, "auto_tick");
        end
        drain(STEP * n + 20, "auto_ticks");
        check("auto_mode_on", int'(auto_mode), 1);
        L = last_adv;

        // Step press event lands on the last prescaler count: one advance.
        model_code = (model_code + 1) % 4;
        push(model_code, STEP, STEP, 1'b1, "coincident_step");
        model_code = (model_code + 1) % 4;
        push(model_code, STEP, STEP, 1'b1, "tick_after_coincident");
        press(1'b0, L + 1, 10);
        drain(40, "coincident");
        L = last_adv;

        // Off-phase step press in AUTO restarts the prescaler.
        off = $urandom_range(1, 4);
        c0 = L + 1 + off;
        model_code = (model_code + 1) % 4;
        push(model_code, STEP, STEP, 1'b1, "tick_before_press");
        model_code = (model_code + 1) % 4;
        push(model_code, c0 + LAT - 1, c0 + LAT + 1, 1'b0, "auto_step");
        for (int i = 0; i < 2; i++) begin
            model_code = (model_code + 1) % 4;
            push(model_code, STEP, STEP, 1'b1, "tick_after_press");
        end
        press(1'b0, c0, 10);
        drain(60, "auto_step");
        L = last_adv;

        // Leave AUTO on a tick cycle: tick discarded, code frozen.
        p0 = pulses;
        mode_press(1'b0, 1'b0, L + 1, r);
        idle(50);
        check("manual_no_pulses", pulses - p0, 0);
        check("manual_frozen_code", int'(code), model_code);
        check("manual_auto_off", int'(auto_mode), 0);

        // Bring code to 00, then mode and step pressed together.
        k = 0;
        while (model_code != 0 && k < 4) begin
            manual_step(12, 12);
            k++;
        end
        drain(30, "realign");
        c0 = cyc + 1;
        model_code = (model_code + 1) % 4;
        push(model_code, c0 + LAT - 1, c0 + LAT + 1, 1'b0, "mode_and_step");
        mode_press(1'b1, 1'b1, c0, r);
        model_code = (model_code + 1) % 4;
        push(model_code, r + STEP, r + STEP, 1'b0, "first_tick2");
        drain(30, "mode_and_step");
        L = last_adv;
        check("pre_reset_code", int'(code), 2);

        // Reset between edges mid-press and mid-count; button held through it.
        wait_cyc(L + 1);
        btn_step_n = 1'b0;
        idle(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_code", int'(code), 0);
        check("async_reset_auto", int'(auto_mode), 0);
        check("async_reset_pulse", int'(step_pulse), 0);
        idle(3);
        rst_n = 1'b1;
        c0 = cyc;
        p0 = pulses;
        model_code = 1;
        push(model_code, c0 + LAT - 1, c0 + LAT + 1, 1'b0, "held_through_reset");
        idle(20);
        drain(20, "held_through_reset");
        btn_step_n = 1'b1;
        idle(40);
        check("after_reset_pulses", pulses - p0, 1);
        check("after_reset_code", int'(code), model_code);
        check("after_reset_auto", int'(auto_mode), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 240000, giving the debounce stability window in clk cycles (10 ms at 24 MHz), legal range >= 1.
REQ-002 The block SHALL have parameter STEP_CYCLES, default 12000000, giving the auto-advance period in clk cycles (0.5 s at 24 MHz), legal range >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port btn_step_n, input, 1 bit: asynchronous pushbutton, low = pressed; one press advances the colour code.
REQ-006 The block SHALL have port btn_mode_n, input, 1 bit: asynchronous pushbutton, low = pressed; one press toggles manual/auto mode.
REQ-007 The block SHALL have port code, output, 2 bits: colour code for the downstream LED decoder, with code[0] driving in0 and code[1] driving in1 (00 off, 01 red, 10 green, 11 blue).
REQ-008 The block SHALL have port auto_mode, output, 1 bit: high while the mode FSM is in AUTO.
REQ-009 The block SHALL have port step_pulse, output, 1 bit: one-cycle strobe, high in the cycle in which code takes a new value.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer, and both flops SHALL reset to 1 (released).
REQ-011 Each button SHALL have a debounced state, reset to 1, that takes the synchronized value only after that value has differed from the debounced state for DEB_CYCLES consecutive cycles.
REQ-012 The debounce counter SHALL clear in any cycle where the synchronized value equals the debounced state, so that any shorter glitch is fully discarded.
REQ-013 A press event SHALL be a one-cycle internal pulse in the cycle after the debounced state goes from 1 to 0; a 0-to-1 transition (release) SHALL produce no event.
REQ-014 A held button SHALL yield exactly one press event, regardless of hold duration.
REQ-015 The mode FSM SHALL have two states, MANUAL and AUTO, and a mode press event SHALL toggle between them.
REQ-016 The prescaler SHALL count 0..STEP_CYCLES-1 while in AUTO and SHALL be held at 0 while in MANUAL.
REQ-017 In AUTO, a tick SHALL occur when the prescaler is at STEP_CYCLES-1, and the prescaler SHALL then wrap to 0.
REQ-018 On the MANUAL-to-AUTO transition the prescaler SHALL start from 0, so the first tick occurs STEP_CYCLES cycles after auto_mode rises.
REQ-019 An advance request SHALL be a step press event in either state, or a tick in AUTO.
REQ-020 On an advance request, code SHALL increment modulo 4 (00->01->10->11->00) on the next clock edge, and step_pulse SHALL be high for exactly the following cycle.
REQ-021 A step press in AUTO SHALL also restart the prescaler at 0.
REQ-022 A step press and a tick in the same cycle SHALL advance code by one only, and the prescaler SHALL restart at 0.
REQ-023 A mode press and a step press in the same cycle SHALL toggle the mode and advance code by one.
REQ-024 Toggling to MANUAL SHALL leave code unchanged, and a tick pending in that cycle SHALL be discarded.
REQ-025 Total latency from a stable button-low level to the code change SHALL be 2 (sync) + DEB_CYCLES + 1 (edge detect) + 1 (code register) cycles, +/-1 cycle.
REQ-026 The code, auto_mode and step_pulse outputs SHALL all be driven directly from flops.

Reset
REQ-027 Assertion of rst_n low SHALL, immediately and without a clock edge, force code=00, auto_mode=0, step_pulse=0, mode=MANUAL, prescaler=0, debounce counters=0, and synchronizer and debounced states=1.
REQ-028 Reset asserted mid-press or mid-count SHALL discard all partial debounce and prescaler progress.
REQ-029 The block SHALL resume from the reset values on the first rising clk edge after rst_n returns high.
REQ-030 A button already held low at reset release SHALL produce one press event after the debounce window.

Verification
All scenarios use DEB_CYCLES=4 and STEP_CYCLES=8.
REQ-031 The bench SHALL cover: rst_n low between clock edges while code=10 -> code=00, auto_mode=0 immediately.
REQ-032 The bench SHALL cover: btn_step_n low for 3 cycles then high -> code stays 00, and step_pulse is never high.
REQ-033 The bench SHALL cover: four clean step presses of 20 cycles each -> code goes 01, 10, 11, 00 with exactly four step_pulse strobes, and holding low for 100 cycles gives one advance only.
REQ-034 The bench SHALL cover: a mode press -> auto_mode=1, and code advances every 8 cycles with step_pulse on each advance.
REQ-035 The bench SHALL cover: in AUTO, a step press event coincident with prescaler=7 -> a single advance, with the next tick 8 cycles later.
REQ-036 The bench SHALL cover: a second mode press -> auto_mode=0, code is frozen, and no step_pulse occurs over 50 cycles.
